// File: rtl/ov_stream_gen_pkg.sv
// Shared definitions for the synthetic OV7670-style source: pattern codes,
// timing FSM states and the luminance selection helper.
package ov_gen_pkg;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_EDGE  = 2'd2;
    localparam logic [1:0] PAT_FLAT  = 2'd3;

    localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BACK   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FRONT  = 3'd4
    } gen_state_e;

    // Luminance of one pixel; right_half marks pixels at or past mid-width.
    function automatic logic [7:0] pick_luma(input logic [1:0] pat, input logic [7:0] x,
                                             input logic [7:0] y, input logic right_half);
        logic [7:0] luma;
        case (pat)
            PAT_HRAMP: luma = x;
            PAT_VRAMP: luma = y;
            PAT_EDGE:  luma = right_half ? 8'hFF : 8'h00;
            PAT_FLAT:  luma = CHROMA_NEUTRAL;
            default:   luma = 8'h00;
        endcase
        return luma;
    endfunction

endpackage

// File: rtl/ov_stream_gen_if.sv
// Camera-side pins of the generator plus its control/status handshake.
interface ov_stream_gen_if;
    logic       enable;
    logic [1:0] pattern;
    logic       pclk_o;
    logic       href_o;
    logic       vsync_o;
    logic [7:0] data_o;
    logic       busy;
    logic       frame_done;

    modport master (input enable, input pattern,
                    output pclk_o, output href_o, output vsync_o, output data_o,
                    output busy, output frame_done);
    modport slave  (output enable, output pattern,
                    input pclk_o, input href_o, input vsync_o, input data_o,
                    input busy, input frame_done);
endinterface

// File: rtl/ov_stream_gen_pclk_tick_gen.sv
// PCLK divider: toggles pclk every CLK_DIV clk cycles while running and flags
// the cycle whose edge takes pclk from 1 to 0.
module pclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic pclk_o,
    output logic fall_tick
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_r;
    logic          pclk_r;

    // Divider counter and pclk level; parked low with a cleared count when idle.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt_r <= '0;
            pclk_r    <= 1'b0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            pclk_r    <= ~pclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
        end
    end

    assign fall_tick = run & pclk_r & (div_cnt_r == DIV_LAST);
    assign pclk_o    = pclk_r;

endmodule

// File: rtl/ov_stream_gen.sv
// Synthetic camera source: frame/line timing FSM, pattern latch and YUYV byte
// mux, all outputs registered and updated on the PCLK falling edge.
module ov_stream_gen
    import ov_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 240,
    parameter int V_FRONT  = 10,
    parameter int CLK_DIV  = 2
) (
    input  logic             clk,
    input  logic             rst,
    ov_stream_gen_if.master  bus
);
    localparam int LINE_LEN = H_ACTIVE + H_BLANK;
    localparam int HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int V_MAX_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int VW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);

    gen_state_e    state_r, nxt_state_s;
    logic [HW-1:0] h_cnt_r, nxt_h_s;
    logic [VW-1:0] v_cnt_r, nxt_v_s;
    logic [1:0]    pat_r, nxt_pat_s;
    logic          load_s, done_s, fall_tick_s, pclk_s;
    logic          line_end_s, last_line_s;
    int            lines_s;
    logic          href_n_s;
    logic [7:0]    data_n_s;
    logic          href_r, vsync_r, busy_r, frame_done_r;
    logic [7:0]    data_r;

    pclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_pclk (
        .clk       (clk),
        .rst       (rst),
        .run       (state_r != ST_IDLE),
        .pclk_o    (pclk_s),
        .fall_tick (fall_tick_s)
    );

    // Line count of the current vertical region and end-of-line/region flags.
    always_comb begin
        case (state_r)
            ST_SYNC:   lines_s = V_SYNC;
            ST_BACK:   lines_s = V_BACK;
            ST_ACTIVE: lines_s = V_ACTIVE;
            ST_FRONT:  lines_s = V_FRONT;
            default:   lines_s = 1;
        endcase
        line_end_s  = (h_cnt_r == H_LAST);
        last_line_s = (32'(v_cnt_r) == 32'(lines_s - 1));
    end

    // Next state and counters; everything outside IDLE advances on fall_tick only.
    always_comb begin
        nxt_state_s = state_r;
        nxt_h_s     = h_cnt_r;
        nxt_v_s     = v_cnt_r;
        nxt_pat_s   = pat_r;
        load_s      = 1'b0;
        done_s      = 1'b0;
        if (state_r == ST_IDLE) begin
            if (bus.enable) begin
                nxt_state_s = ST_SYNC;
                nxt_h_s     = '0;
                nxt_v_s     = '0;
                nxt_pat_s   = bus.pattern;
                load_s      = 1'b1;
            end else begin
                load_s      = 1'b0;
            end
        end else if (fall_tick_s) begin
            load_s = 1'b1;
            if (!line_end_s) begin
                nxt_h_s = h_cnt_r + 1'b1;
            end else if (!last_line_s) begin
                nxt_h_s = '0;
                nxt_v_s = v_cnt_r + 1'b1;
            end else begin
                nxt_h_s = '0;
                nxt_v_s = '0;
                case (state_r)
                    ST_SYNC:   nxt_state_s = ST_BACK;
                    ST_BACK:   nxt_state_s = ST_ACTIVE;
                    ST_ACTIVE: nxt_state_s = ST_FRONT;
                    ST_FRONT: begin
                        done_s = 1'b1;
                        if (bus.enable) begin
                            nxt_state_s = ST_SYNC;
                            nxt_pat_s   = bus.pattern;
                        end else begin
                            nxt_state_s = ST_IDLE;
                        end
                    end
                    default:   nxt_state_s = ST_IDLE;
                endcase
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Byte presented for the upcoming PCLK period: Y on even bytes, neutral chroma on odd.
    always_comb begin
        href_n_s = (nxt_state_s == ST_ACTIVE) && (32'(nxt_h_s) < 32'(H_ACTIVE));
        if (!href_n_s) begin
            data_n_s = 8'h00;
        end else if (nxt_h_s[0]) begin
            data_n_s = CHROMA_NEUTRAL;
        end else begin
            data_n_s = pick_luma(nxt_pat_s, 8'(nxt_h_s >> 1), 8'(nxt_v_s),
                                 32'(nxt_h_s >> 1) >= 32'(H_ACTIVE / 4));
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            h_cnt_r      <= '0;
            v_cnt_r      <= '0;
            pat_r        <= PAT_HRAMP;
            href_r       <= 1'b0;
            vsync_r      <= 1'b0;
            busy_r       <= 1'b0;
            data_r       <= 8'h00;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= done_s;
            if (load_s) begin
                state_r <= nxt_state_s;
                h_cnt_r <= nxt_h_s;
                v_cnt_r <= nxt_v_s;
                pat_r   <= nxt_pat_s;
                href_r  <= href_n_s;
                vsync_r <= (nxt_state_s == ST_SYNC);
                busy_r  <= (nxt_state_s != ST_IDLE);
                data_r  <= data_n_s;
            end
        end
    end

    assign bus.pclk_o     = pclk_s;
    assign bus.href_o     = href_r;
    assign bus.vsync_o    = vsync_r;
    assign bus.data_o     = data_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ov_stream_gen.sv
// Self-checking bench: per-cycle comparison against a frame-position model,
// pattern byte tables, and hand-written timing/enable/reset sequences.
module tb_ov_stream_gen;
    localparam int HA = 8, HB = 4, VS = 1, VB = 1, VA = 3, VF = 1, CD = 2;
    localparam int L     = HA + HB;
    localparam int NL    = VS + VB + VA + VF;
    localparam int PER   = 2 * CD;
    localparam int FRAME = NL * L * PER;

    typedef struct {
        int          pat;
        int          y;
        logic [63:0] b;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ov_stream_gen_if bus();

    ov_stream_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB),
                    .V_ACTIVE(VA), .V_FRONT(VF), .CLK_DIV(CD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0;
    int m_c = -1, m_pat = 0, cyc = 0, frames_seen = 0;
    bit m_done = 1'b0;
    logic prev_pclk = 1'b0, prev_busy = 1'b0;
    int pclk_changes = 0, vs_cnt = 0, hr_run = 0;
    int hr_q[$], done_q[$], busy_q[$];
    logic [7:0] cap [4][24];
    int cap_n [4];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected pins at cycle offset c of a frame, derived from line/pixel position.
    function automatic void model_out(input int c, input int pat, output logic [7:0] d,
                                      output logic pc, output logic hr, output logic vs);
        int k, line, h, a;
        k = c / PER; line = k / L; h = k % L; a = line - (VS + VB);
        pc = ((c % PER) >= CD);
        vs = (line < VS);
        hr = (a >= 0) && (a < VA) && (h < HA);
        if (!hr) d = 8'h00;
        else if (h % 2 == 1) d = 8'h80;
        else begin
            case (pat)
                0: d = 8'(h / 2);
                1: d = 8'(a);
                2: d = ((h / 2) >= HA / 4) ? 8'hFF : 8'h00;
                default: d = 8'h80;
            endcase
        end
    endfunction

    task automatic step();
        logic en_s, rst_s;
        int pat_s;
        logic [7:0] ed;
        logic ep, eh, ev;
        int exp_v, act_v;
        en_s = bus.enable; pat_s = int'(bus.pattern); rst_s = rst;
        @(posedge clk);
        cyc++;
        m_done = 1'b0;
        if (rst_s) m_c = -1;
        else if (m_c < 0) begin
            if (en_s) begin m_c = 0; m_pat = pat_s; end
        end else begin
            m_c++;
            if (m_c == FRAME) begin
                m_done = 1'b1;
                frames_seen++;
                if (en_s) begin m_c = 0; m_pat = pat_s; end
                else m_c = -1;
            end
        end
        #1;
        if (m_c < 0) begin ed = 8'h00; ep = 1'b0; eh = 1'b0; ev = 1'b0; end
        else model_out(m_c, m_pat, ed, ep, eh, ev);
        exp_v = {ep, eh, ev, (m_c >= 0), m_done, ed};
        act_v = {bus.pclk_o, bus.href_o, bus.vsync_o, bus.busy, bus.frame_done, bus.data_o};
        chk($sformatf("cycle%0d_pins", cyc), act_v, exp_v);
        if (bus.pclk_o && !prev_pclk && bus.href_o && m_c >= 0 && cap_n[m_pat] < 24) begin
            cap[m_pat][cap_n[m_pat]] = bus.data_o;
            cap_n[m_pat]++;
        end
        if (bus.pclk_o != prev_pclk) pclk_changes++;
        if (frames_seen == 0 && bus.vsync_o) vs_cnt++;
        if (frames_seen == 0) begin
            if (bus.href_o) hr_run++;
            else if (hr_run > 0) begin hr_q.push_back(hr_run); hr_run = 0; end
        end
        if (bus.frame_done) done_q.push_back(cyc);
        if (bus.busy && !prev_busy) busy_q.push_back(cyc);
        prev_pclk = bus.pclk_o;
        prev_busy = bus.busy;
    endtask

    initial begin
        vec_t tbl[12];
        int snap, guard, drop_at;
        tbl[0]  = '{pat: 0, y: 0, b: 64'h00_80_01_80_02_80_03_80};
        tbl[1]  = '{pat: 0, y: 1, b: 64'h00_80_01_80_02_80_03_80};
        tbl[2]  = '{pat: 0, y: 2, b: 64'h00_80_01_80_02_80_03_80};
        tbl[3]  = '{pat: 1, y: 0, b: 64'h00_80_00_80_00_80_00_80};
        tbl[4]  = '{pat: 1, y: 1, b: 64'h01_80_01_80_01_80_01_80};
        tbl[5]  = '{pat: 1, y: 2, b: 64'h02_80_02_80_02_80_02_80};
        tbl[6]  = '{pat: 2, y: 0, b: 64'h00_80_00_80_FF_80_FF_80};
        tbl[7]  = '{pat: 2, y: 1, b: 64'h00_80_00_80_FF_80_FF_80};
        tbl[8]  = '{pat: 2, y: 2, b: 64'h00_80_00_80_FF_80_FF_80};
        tbl[9]  = '{pat: 3, y: 0, b: 64'h80_80_80_80_80_80_80_80};
        tbl[10] = '{pat: 3, y: 1, b: 64'h80_80_80_80_80_80_80_80};
        tbl[11] = '{pat: 3, y: 2, b: 64'h80_80_80_80_80_80_80_80};
        for (int p = 0; p < 4; p++) cap_n[p] = 0;

        // Reset, then a quiet idle window.
        bus.enable = 1'b0; bus.pattern = 2'd0; rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        snap = pclk_changes;
        repeat (100) step();
        chk("idle_pclk_static", pclk_changes - snap, 0);

        // Four back-to-back frames; the next pattern is requested mid-frame.
        bus.enable = 1'b1; bus.pattern = 2'd0;
        step();
        for (int f = 0; f < 4; f++) begin
            repeat (50) step();
            bus.pattern = 2'(f + 1);
            repeat (FRAME - 50) step();
        end
        chk("vsync_cycles", vs_cnt, 48);
        chk("href_pulses", hr_q.size(), 3);
        foreach (hr_q[i]) chk($sformatf("href_len%0d", i), hr_q[i], HA * PER);
        chk("done_count_4frames", done_q.size(), 4);
        if (done_q.size() > 0 && busy_q.size() > 0)
            chk("first_done_delay", done_q[0] - busy_q[0], FRAME);
        for (int i = 1; i < done_q.size(); i++)
            chk($sformatf("done_gap%0d", i), done_q[i] - done_q[i-1], FRAME);
        for (int r = 0; r < 12; r++) begin
            logic [63:0] row;
            row = tbl[r].b;
            for (int i = 0; i < 8; i++)
                chk($sformatf("tbl_p%0d_y%0d_b%0d", tbl[r].pat, tbl[r].y, i),
                    int'(cap[tbl[r].pat][tbl[r].y * 8 + i]), int'(row[63 - 8*i -: 8]));
        end

        // Two frames under random pattern churn, enable dropped inside the second.
        done_q.delete();
        drop_at = FRAME + int'($urandom_range(1, FRAME - 2));
        for (int i = 0; i < drop_at; i++) begin
            if ($urandom_range(0, 7) == 0) bus.pattern = 2'($urandom_range(0, 3));
            step();
        end
        bus.enable = 1'b0;
        guard = 0;
        while (m_c >= 0 && guard < 2 * FRAME) begin step(); guard++; end
        repeat (20) step();
        chk("drop_done_count", done_q.size(), 2);
        if (done_q.size() == 2) chk("drop_done_gap", done_q[1] - done_q[0], FRAME);
        chk("drop_idle_busy", int'(bus.busy), 0);

        // Reset during ACTIVE, then restart.
        done_q.delete();
        bus.enable = 1'b1; bus.pattern = 2'($urandom_range(0, 3));
        step();
        repeat (110) step();
        chk("pre_rst_href", int'(bus.href_o), 1);
        rst = 1'b1;
        step();
        chk("rst_outputs", int'({bus.pclk_o, bus.href_o, bus.vsync_o, bus.busy,
                                 bus.frame_done, bus.data_o}), 0);
        rst = 1'b0;
        step();
        chk("restart_vsync", int'(bus.vsync_o), 1);
        chk("restart_busy", int'(bus.busy), 1);
        bus.enable = 1'b0;
        guard = 0;
        while (m_c >= 0 && guard < 2 * FRAME) begin step(); guard++; end
        repeat (5) step();
        chk("restart_done_count", done_q.size(), 1);
        chk("final_busy", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ov_stream_gen.md
# ov_stream_gen

Synthetic OV7670-style camera source for the Sobel pipeline. Generates PCLK/HREF/VSYNC timing and a YUYV byte stream from selectable test patterns, so the capture, line-buffer and Sobel path can be exercised in simulation and on the board without a sensor. It drives the same pins the capture logic samples, at the far end of the camera interface.

## Interface
- `H_ACTIVE`, default 640: bytes per active line (2 × pixels, QVGA YUYV); must be even.
- `H_BLANK`, default 144: PCLK periods with HREF low after each active line.
- `V_SYNC`, default 3: lines with VSYNC high.
- `V_BACK`, default 17: blank lines after VSYNC.
- `V_ACTIVE`, default 240: active lines per frame.
- `V_FRONT`, default 10: blank lines after the active region.
- `CLK_DIV`, default 2: clk cycles per PCLK half-period, ≥1.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: start frames; level-sensitive, sampled at frame boundaries.
- `pattern` in 2: test pattern select, latched at frame start.
- `pclk_o` in/out n/a; `pclk_o` out 1: generated pixel clock.
- `href_o` out 1: line valid.
- `vsync_o` out 1: frame sync, active-high.
- `data_o` out 8: pixel byte.
- `busy` out 1: high while a frame is in progress.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation
- States:
  - IDLE
  - SYNC: V_SYNC lines
  - BACK: V_BACK lines
  - ACTIVE: V_ACTIVE lines
  - FRONT: V_FRONT lines
- Every line, including blank lines, lasts L = H_ACTIVE + H_BLANK PCLK periods.
- `h_cnt` counts 0..L-1. `v_cnt` counts lines within the current state.
- Transitions:
  - IDLE→SYNC on `enable`=1.
  - Each later state advances when its last line ends.
  - FRONT→SYNC if `enable`=1 at that point, else FRONT→IDLE.
- `vsync_o`=1 only in SYNC.
- `href_o`=1 only in ACTIVE while `h_cnt` < H_ACTIVE.
- Byte order within a line is Y U Y V. Bytes with even `h_cnt` are luminance. Odd bytes are always 0x80.
- Luminance for pixel x = `h_cnt`>>1 on active line y = `v_cnt`:
  - pattern 0: x[7:0], horizontal ramp.
  - pattern 1: y[7:0], vertical ramp.
  - pattern 2: 0xFF if x ≥ H_ACTIVE/4, else 0x00 (vertical edge at mid-width).
  - pattern 3: constant 0x80.
- `data_o` = 0x00 whenever `href_o`=0.
- `pattern` is latched on entry to SYNC and held for the whole frame.
- Deasserting `enable` mid-frame completes the current frame. No truncation.
- `busy`=1 in every state except IDLE.
- `frame_done` pulses in the clk cycle where FRONT's last line ends, including when the generator goes straight back to SYNC.

## Timing
- Reset values: state IDLE, counters 0, and `pclk_o`, `href_o`, `vsync_o`, `busy`, `frame_done` = 0, `data_o` = 0x00.
- `rst` mid-frame returns to IDLE on the next edge. No `frame_done` is emitted.
- In IDLE `pclk_o` is held at 0. Outside IDLE it toggles every CLK_DIV clk cycles.
- `href_o`, `vsync_o` and `data_o` change only in the clk cycle where `pclk_o` goes 1→0. They are then stable for a full PCLK period across the following rising edge, which is the sampling edge.
- Start: `enable` is sampled high in IDLE at edge T. From T+1, `busy`=1, `vsync_o`=1 and `pclk_o`=0. The first PCLK rise occurs at T+1+CLK_DIV.
- Frame length is exactly (V_SYNC+V_BACK+V_ACTIVE+V_FRONT) × L × 2 × CLK_DIV clk cycles, with back-to-back frames gapless.
- Counter widths are $clog2 of their maximum value. All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `ov_gen_pkg`: pattern codes (PAT_HRAMP=0, PAT_VRAMP=1, PAT_EDGE=2, PAT_FLAT=3), state enum, CHROMA_NEUTRAL=8'h80.
- Sub-module `pclk_tick_gen`: holds the CLK_DIV divider and drives `pclk_o`. Emits a one-cycle `fall_tick` that advances the timing FSM and the counters.
- Top level: FSM, `h_cnt`/`v_cnt`, pattern latch, and byte mux.

## Test plan
Benches use H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=3, V_FRONT=1, CLK_DIV=2 (L=12, frame = 6×12×4 = 288 cycles).
- Reset, then idle with `enable`=0 → all outputs 0, `pclk_o` static for 100 cycles.
- `enable`=1, pattern 0 → `vsync_o` high for 48 cycles. Each active line samples 00 80 01 80 02 80 03 80 on PCLK rises. 3 HREF pulses, each 32 cycles. `frame_done` at cycle 288.
- Pattern 1 → line y yields y 80 y 80 y 80 y 80 for y = 0, 1, 2.
- Pattern 2 → each line yields 00 80 00 80 FF 80 FF 80. Changing `pattern` mid-frame has no effect until the next SYNC.
- `enable` held high for 2 frames, then dropped during frame 2 → exactly 2 `frame_done` pulses 288 cycles apart, no gap, then IDLE with `busy`=0.
- `rst` asserted in ACTIVE → next cycle all outputs are at reset values. Re-enabling restarts from SYNC.
